tri_bus_arbiter: RTL and testbench
==================================

TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, which sets the number of requesters sharing one tristate data bus.
REQ-002 The block SHALL have parameter TURNAROUND, default 1, which sets the number of cycles (1..7) during which all drivers are off between bus owners.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, which sets the maximum number of consecutive grant cycles (2..255) while another requester is pending.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  N_REQ  level requests; bit k high means requester k wants the bus.
REQ-008 grant  output  N_REQ  one-hot or zero; registered; bit k high means requester k owns the bus.
REQ-009 oe_n  output  N_REQ  active-low buffer enables for the bufif0-style drivers; registered; oe_n[k] == ~grant[k].
REQ-010 owner  output  clog2(N_REQ)  index of the current owner; 0 when grant == 0.
REQ-011 bus_busy  output  1  high while any grant bit is high.
REQ-012 turn  output  1  high during turnaround cycles.

Function
REQ-013 The FSM SHALL have three states: IDLE, GRANT, TURN.
REQ-014 At most one oe_n bit SHALL be low in any cycle, including across reset and state changes.
REQ-015 Arbitration SHALL be round-robin: search from index rr_ptr upward, wrapping N_REQ-1 to 0; the first requester with req high wins.
REQ-016 IDLE: grant = 0; if any req bit is sampled high, the winner's grant SHALL be high on the next cycle and the state SHALL become GRANT; otherwise the state stays IDLE.
REQ-017 Latency from req rising in IDLE to grant SHALL be exactly 1 cycle.
REQ-018 GRANT: hold_cnt (8 bits) SHALL load 0 on grant entry and increment each GRANT cycle, saturating at MAX_HOLD-1.
REQ-019 GRANT SHALL release when req[owner] is sampled low.
REQ-020 GRANT SHALL also release when hold_cnt == MAX_HOLD-1 and any other req bit is high.
REQ-021 With no other requester pending, the owner SHALL keep the bus indefinitely.
REQ-022 On release, grant and oe_n SHALL go all-off on the next cycle, the state SHALL become TURN, and rr_ptr SHALL become (owner+1) mod N_REQ.
REQ-023 TURN SHALL last exactly TURNAROUND cycles with turn = 1 and grant = 0.
REQ-024 In the last TURN cycle, req is sampled: a winner is granted on the next cycle, otherwise the state SHALL become IDLE.
REQ-025 The minimum gap between two owners' grant intervals SHALL be exactly TURNAROUND cycles.
REQ-026 A requester that drops req before being granted SHALL NOT be granted; no request latching is performed.
REQ-027 If the owner drops req in the same cycle hold_cnt reaches the limit, the result SHALL be a single release.
REQ-028 rr_ptr SHALL advance only on release, never in IDLE.
REQ-029 Requests arriving during TURN SHALL be considered only at TURN exit.

Reset
REQ-030 While rst is high at a clock edge, the next state SHALL be: state IDLE, grant 0, oe_n all 1, owner 0, bus_busy 0, turn 0, hold_cnt 0, rr_ptr 0.
REQ-031 Reset asserted mid-GRANT SHALL disable all drivers on the very next edge, with no turnaround applied.
REQ-032 On the first cycle after rst deasserts, requests SHALL be arbitrated as in IDLE.

Verification
REQ-033 Single request: req=0100 in IDLE at cycle t -> grant=0100, oe_n=1011, owner=2 at t+1; req drops at t+5 -> grant=0000, turn=1 at t+6; IDLE at t+7.
REQ-034 Round-robin: req=1111 held continuously, MAX_HOLD=4, TURNAROUND=1 -> owners 0,1,2,3,0 in order; each holds 4 cycles, separated by 1 idle cycle.
REQ-035 Lone hog: req=0001 only, held for 100 cycles -> grant=0001 throughout, no release, bus_busy=1.
REQ-036 TURNAROUND=3: owner 1 releases while req[2] is high -> exactly 3 cycles with oe_n=1111 and turn=1, then grant=0100.
REQ-037 Reset mid-grant: grant=1000, rst=1 for 1 cycle -> oe_n=1111 next cycle; after rst deasserts with req=1000 -> grant=1000 one cycle later.
REQ-038 Bus-contention checker, active in all scenarios: popcount(~oe_n) <= 1 every cycle and oe_n == ~grant.

Source files
------------

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for N_REQ requesters sharing one tristate bus.
// Registered grant/oe_n with a TURNAROUND gap of all-drivers-off between owners.
module tri_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_REQ-1:0]                            req,
  output logic [N_REQ-1:0]                            grant,
  output logic [N_REQ-1:0]                            oe_n,
  output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0]  owner,
  output logic                                        bus_busy,
  output logic                                        turn
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  localparam logic [7:0]    HOLD_LIM  = 8'(MAX_HOLD - 1);
  localparam logic [2:0]    TURN_LAST = 3'(TURNAROUND - 1);
  localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);

  logic [1:0]       state, state_d;
  logic [7:0]       hold_cnt, hold_cnt_d;
  logic [2:0]       turn_cnt, turn_cnt_d;
  logic [OW-1:0]    rr_ptr, rr_ptr_d;
  logic [OW-1:0]    owner_d;
  logic [OW-1:0]    win_idx, cand;
  logic [N_REQ-1:0] grant_d;
  logic             win_found;
  logic             turn_d;
  logic             release_bus;
  logic             start_grant;

  // First active requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = OW'((32'(rr_ptr) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign release_bus = !req[owner] || ((hold_cnt == HOLD_LIM) && (|(req & ~grant)));

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    owner_d     = owner;
    hold_cnt_d  = hold_cnt;
    turn_cnt_d  = turn_cnt;
    rr_ptr_d    = rr_ptr;
    turn_d      = turn;
    start_grant = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) start_grant = 1'b1;
      end
      GRANT: begin
        if (release_bus) begin
          state_d    = TURN;
          grant_d    = '0;
          owner_d    = '0;
          turn_d     = 1'b1;
          turn_cnt_d = '0;
          rr_ptr_d   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        end else if (hold_cnt != HOLD_LIM) begin
          hold_cnt_d = hold_cnt + 8'd1;
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          turn_d = 1'b0;
          if (win_found) start_grant = 1'b1;
          else           state_d     = IDLE;
        end else begin
          turn_cnt_d = turn_cnt + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
        turn_d  = 1'b0;
      end
    endcase

    if (start_grant) begin
      state_d          = GRANT;
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      owner_d          = win_idx;
      hold_cnt_d       = '0;
    end
  end

  // oe_n and bus_busy are derived from next-state grant so they stay in lockstep with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      oe_n     <= '1;
      owner    <= '0;
      bus_busy <= 1'b0;
      turn     <= 1'b0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      oe_n     <= ~grant_d;
      owner    <= owner_d;
      bus_busy <= |grant_d;
      turn     <= turn_d;
      hold_cnt <= hold_cnt_d;
      turn_cnt <= turn_cnt_d;
      rr_ptr   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scenario bench for tri_bus_arbiter: two instances (TURNAROUND 1 and 3, MAX_HOLD 4),
// per-cycle expectations queued at drive time and popped after each edge.
module tb_tri_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] grant_a, oe_n_a, grant_b, oe_n_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, turn_a, busy_b, turn_b;
  logic       chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rs;
    logic [3:0] r;
    logic [3:0] g;
    logic [1:0] o;
    logic       t;
  } step_t;

  step_t stim_q[$];
  step_t exp_q[$];

  always #5 clk = ~clk;

  tri_bus_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .grant(grant_a), .oe_n(oe_n_a),
    .owner(owner_a), .bus_busy(busy_a), .turn(turn_a)
  );

  tri_bus_arbiter #(.N_REQ(4), .TURNAROUND(3), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .grant(grant_b), .oe_n(oe_n_b),
    .owner(owner_b), .bus_busy(busy_b), .turn(turn_b)
  );

  // Bus-contention watch on both instances, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks += 2;
      if ($countones(~oe_n_a) > 1 || oe_n_a !== ~grant_a) begin
        n_fail++;
        $display("FAIL contention_a t=%0t: oe_n=%b grant=%b, required <=1 low and oe_n==~grant", $time, oe_n_a, grant_a);
      end
      if ($countones(~oe_n_b) > 1 || oe_n_b !== ~grant_b) begin
        n_fail++;
        $display("FAIL contention_b t=%0t: oe_n=%b grant=%b, required <=1 low and oe_n==~grant", $time, oe_n_b, grant_b);
      end
    end
  end

  task automatic add(input logic rs, input logic [3:0] r, input logic [3:0] g,
                     input logic [1:0] o, input logic t);
    step_t s;
    s.rs = rs; s.r = r; s.g = g; s.o = o; s.t = t;
    stim_q.push_back(s);
  endtask

  task automatic test_reset;
    step_t s, e;
    add(1, 4'b0000, 4'b0000, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      rst = s.rs; req_a = s.r; req_b = s.r;
      exp_q.push_back(s);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks += 2;
      if ({grant_a, oe_n_a, owner_a, busy_a, turn_a} !== {e.g, ~e.g, e.o, |e.g, e.t}) begin
        n_fail++;
        $display("FAIL reset_a: grant=%b oe_n=%b owner=%0d busy=%b turn=%b, expected grant=%b owner=%0d turn=%b",
                 grant_a, oe_n_a, owner_a, busy_a, turn_a, e.g, e.o, e.t);
      end
      if ({grant_b, oe_n_b, owner_b, busy_b, turn_b} !== {e.g, ~e.g, e.o, |e.g, e.t}) begin
        n_fail++;
        $display("FAIL reset_b: grant=%b oe_n=%b owner=%0d busy=%b turn=%b, expected grant=%b owner=%0d turn=%b",
                 grant_b, oe_n_b, owner_b, busy_b, turn_b, e.g, e.o, e.t);
      end
    end
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_single;
    step_t s, e;
    int k = 0;
    for (int c = 0; c < 5; c++) add(0, 4'b0100, 4'b0100, 2, 0);
    add(0, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      rst = s.rs; req_a = s.r;
      exp_q.push_back(s);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({grant_a, oe_n_a, owner_a, busy_a, turn_a} !== {e.g, ~e.g, e.o, |e.g, e.t}) begin
        n_fail++;
        $display("FAIL single[%0d]: grant=%b oe_n=%b owner=%0d busy=%b turn=%b, expected grant=%b owner=%0d turn=%b",
                 k, grant_a, oe_n_a, owner_a, busy_a, turn_a, e.g, e.o, e.t);
      end
      k++;
    end
  endtask

  task automatic test_round_robin;
    step_t s, e;
    int k = 0;
    add(1, 4'b0000, 4'b0000, 0, 0);
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 4; c++) add(0, 4'b1111, 4'(1 << (o % 4)), 2'(o % 4), 0);
      if (o < 4) add(0, 4'b1111, 4'b0000, 0, 1);
    end
    add(0, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b0000, 4'b0000, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      rst = s.rs; req_a = s.r;
      exp_q.push_back(s);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({grant_a, oe_n_a, owner_a, busy_a, turn_a} !== {e.g, ~e.g, e.o, |e.g, e.t}) begin
        n_fail++;
        $display("FAIL round_robin[%0d]: grant=%b oe_n=%b owner=%0d busy=%b turn=%b, expected grant=%b owner=%0d turn=%b",
                 k, grant_a, oe_n_a, owner_a, busy_a, turn_a, e.g, e.o, e.t);
      end
      k++;
    end
  endtask

  task automatic test_lone_hog;
    step_t s, e;
    int k = 0;
    for (int c = 0; c < 100; c++) add(0, 4'b0001, 4'b0001, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b0000, 4'b0000, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      rst = s.rs; req_a = s.r;
      exp_q.push_back(s);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({grant_a, oe_n_a, owner_a, busy_a, turn_a} !== {e.g, ~e.g, e.o, |e.g, e.t}) begin
        n_fail++;
        $display("FAIL lone_hog[%0d]: grant=%b oe_n=%b owner=%0d busy=%b turn=%b, expected grant=%b owner=%0d turn=%b",
                 k, grant_a, oe_n_a, owner_a, busy_a, turn_a, e.g, e.o, e.t);
      end
      k++;
    end
  endtask

  // Requester 2 asserts briefly behind owner 1 and withdraws: it must never be granted.
  task automatic test_no_latch;
    step_t s, e;
    int k = 0;
    add(0, 4'b0010, 4'b0010, 1, 0);
    add(0, 4'b0110, 4'b0010, 1, 0);
    add(0, 4'b0010, 4'b0010, 1, 0);
    add(0, 4'b0010, 4'b0010, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      rst = s.rs; req_a = s.r;
      exp_q.push_back(s);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({grant_a, oe_n_a, owner_a, busy_a, turn_a} !== {e.g, ~e.g, e.o, |e.g, e.t}) begin
        n_fail++;
        $display("FAIL no_latch[%0d]: grant=%b oe_n=%b owner=%0d busy=%b turn=%b, expected grant=%b owner=%0d turn=%b",
                 k, grant_a, oe_n_a, owner_a, busy_a, turn_a, e.g, e.o, e.t);
      end
      k++;
    end
  endtask

  // Owner drops req on the same cycle the hold limit is hit: exactly one release.
  task automatic test_limit_drop;
    step_t s, e;
    int k = 0;
    add(1, 4'b0000, 4'b0000, 0, 0);
    for (int c = 0; c < 4; c++) add(0, 4'b0011, 4'b0001, 0, 0);
    add(0, 4'b0010, 4'b0000, 0, 1);
    add(0, 4'b0010, 4'b0010, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b0000, 4'b0000, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      rst = s.rs; req_a = s.r;
      exp_q.push_back(s);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({grant_a, oe_n_a, owner_a, busy_a, turn_a} !== {e.g, ~e.g, e.o, |e.g, e.t}) begin
        n_fail++;
        $display("FAIL limit_drop[%0d]: grant=%b oe_n=%b owner=%0d busy=%b turn=%b, expected grant=%b owner=%0d turn=%b",
                 k, grant_a, oe_n_a, owner_a, busy_a, turn_a, e.g, e.o, e.t);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_grant;
    step_t s, e;
    int k = 0;
    add(1, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1000, 4'b1000, 3, 0);
    add(1, 4'b1000, 4'b0000, 0, 0);
    add(0, 4'b1000, 4'b1000, 3, 0);
    add(0, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b0000, 4'b0000, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      rst = s.rs; req_a = s.r;
      exp_q.push_back(s);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({grant_a, oe_n_a, owner_a, busy_a, turn_a} !== {e.g, ~e.g, e.o, |e.g, e.t}) begin
        n_fail++;
        $display("FAIL reset_mid_grant[%0d]: grant=%b oe_n=%b owner=%0d busy=%b turn=%b, expected grant=%b owner=%0d turn=%b",
                 k, grant_a, oe_n_a, owner_a, busy_a, turn_a, e.g, e.o, e.t);
      end
      k++;
    end
  endtask

  // TURNAROUND=3: three dark cycles between owners; a request seen only mid-turn is ignored.
  task automatic test_turnaround3;
    step_t s, e;
    int k = 0;
    req_a = '0;
    add(1, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0010, 4'b0010, 1, 0);
    for (int c = 0; c < 3; c++) add(0, 4'b0110, 4'b0010, 1, 0);
    for (int c = 0; c < 3; c++) add(0, 4'b0110, 4'b0000, 0, 1);
    add(0, 4'b0110, 4'b0100, 2, 0);
    add(0, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b1000, 4'b0000, 0, 1);
    add(0, 4'b1000, 4'b0000, 0, 1);
    add(0, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      rst = s.rs; req_b = s.r;
      exp_q.push_back(s);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({grant_b, oe_n_b, owner_b, busy_b, turn_b} !== {e.g, ~e.g, e.o, |e.g, e.t}) begin
        n_fail++;
        $display("FAIL turnaround3[%0d]: grant=%b oe_n=%b owner=%0d busy=%b turn=%b, expected grant=%b owner=%0d turn=%b",
                 k, grant_b, oe_n_b, owner_b, busy_b, turn_b, e.g, e.o, e.t);
      end
      k++;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_lone_hog;
    test_no_latch;
    test_limit_drop;
    test_reset_mid_grant;
    test_turnaround3;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
